// File: rtl/sram_ctrl_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sram_ctrl_pipe_pkg
//  Purpose  : Shared constants, command encoding and helper function for the
//             pipelined SRAM controller and its response FIFO.
//             Response entries are laid out as {err, rdata}; the err field is
//             only present when SRAM_CTRL_ADDR_CHK_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
package sram_ctrl_pipe_pkg;

    // Deepest SRAM read latency the read-tracking pipeline supports.
    localparam int SRAM_CTRL_RD_LAT_MAX = 2;

    // Width of the error field at the top of a response entry.
    localparam int SRAM_CTRL_ERR_W = 1;

    typedef enum logic {
        CMD_WRITE = 1'b0,
        CMD_READ  = 1'b1
    } cmd_op_e;

    // Ceiling log2 for elaboration-time sizing (sram_clog2(1) == 0).
    function automatic int sram_clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_ctrl_pipe_rsp_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sram_rsp_fifo
//  Purpose  : Generic synchronous FIFO used to buffer SRAM responses.
//             Full/empty come from read/write pointers carrying one extra
//             wrap bit, so no occupancy counter is needed.
//  Ports    : clk, rst        - clock, synchronous active-high reset
//             i_push/i_push_data - write an entry
//             i_pop           - remove the head entry (ignored when empty)
//             o_pop_data      - head entry
//             o_full/o_empty  - status
//  Revision : 1.0 - initial release
// ============================================================================
module sram_rsp_fifo
    import sram_ctrl_pipe_pkg::*;
#(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_PW = sram_clog2(DEPTH);
    localparam logic [c_PW:0] c_PTR_ONE = {{c_PW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_PW:0]    r_wr_ptr;
    logic [c_PW:0]    r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Same index with opposite wrap bits means the writer is a lap ahead.
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[c_PW] != r_rd_ptr[c_PW]) &&
                     (r_wr_ptr[c_PW-1:0] == r_rd_ptr[c_PW-1:0]);

    // A push into a full FIFO is legal when the head leaves in the same cycle.
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    assign o_pop_data = r_mem[r_rd_ptr[c_PW-1:0]];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[c_PW-1:0]] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sram_ctrl_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : sram_ctrl_pipe
//  Purpose  : Bridges a valid/ready cmd/rsp memory channel to a synchronous
//             single-port SRAM with 1- or 2-cycle read latency. A credit
//             counter bounds accepted-but-unreturned transactions to the
//             response FIFO depth, so one command per cycle is sustained and
//             no response is ever dropped under back-pressure.
//  Ports    : clk, rst                      - clock, sync active-high reset
//             sram_cmd_vld/rdy/addr/read/wdata/wmask - command channel
//             sram_rsp_vld/rdy/err/rdata    - response channel
//             sram_cs/we/addr/wem/wdata     - SRAM macro request
//             sram_rdata                    - SRAM read data (RD_LAT after cs)
//  Options  : SRAM_CTRL_ADDR_CHK_EN - flag out-of-range or misaligned commands
//             as errors (no SRAM access, err=1, rdata=0).
//  Revision : 1.0 - initial release
// ============================================================================
module sram_ctrl_pipe
    import sram_ctrl_pipe_pkg::*;
#(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int SRAM_AW   = 14,
    parameter int RD_LAT    = 1,
    parameter int RSP_DEPTH = 4,
    parameter int MEM_BYTES = 65536
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sram_cmd_vld,
    output logic               sram_cmd_rdy,
    input  logic [AW-1:0]      sram_cmd_addr,
    input  logic               sram_cmd_read,
    input  logic [DW-1:0]      sram_cmd_wdata,
    input  logic [DW/8-1:0]    sram_cmd_wmask,
    output logic               sram_rsp_vld,
    input  logic               sram_rsp_rdy,
    output logic               sram_rsp_err,
    output logic [DW-1:0]      sram_rsp_rdata,
    output logic               sram_cs,
    output logic               sram_we,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [DW/8-1:0]    sram_wem,
    output logic [DW-1:0]      sram_wdata,
    input  logic [DW-1:0]      sram_rdata
);

    localparam int c_BW  = DW / 8;
    localparam int c_OFF = sram_clog2(c_BW);
    localparam int c_CW  = sram_clog2(RSP_DEPTH + 1);
    localparam int c_LAT = (RD_LAT >= SRAM_CTRL_RD_LAT_MAX) ? SRAM_CTRL_RD_LAT_MAX : 1;
`ifdef SRAM_CTRL_ADDR_CHK_EN
    localparam int c_EW  = DW + SRAM_CTRL_ERR_W;
`else
    localparam int c_EW  = DW;
`endif

    logic            w_acc;
    logic            w_pop;
    logic            w_cmd_err;
    logic            w_push;
    logic [DW-1:0]   w_rdata_in;
    logic [c_EW-1:0] w_push_data;
    logic [c_EW-1:0] w_head;
    logic            w_fifo_full;
    logic            w_fifo_empty;
    logic [c_CW-1:0] r_cnt;
    logic [c_LAT-1:0] r_vld;
    logic [c_LAT-1:0] r_rd;

    // ------------------------------------------------------------------
    // Handshakes. A pop frees a credit in the same cycle, which keeps the
    // channel at full rate when the FIFO and pipeline are saturated.
    // ------------------------------------------------------------------
    assign sram_rsp_vld = ~w_fifo_empty;
    assign w_pop        = sram_rsp_vld & sram_rsp_rdy;
    assign sram_cmd_rdy = ~rst & ((r_cnt < c_CW'(RSP_DEPTH)) | w_pop);
    assign w_acc        = sram_cmd_vld & sram_cmd_rdy;

    // ------------------------------------------------------------------
    // SRAM request
    // ------------------------------------------------------------------
    assign sram_cs    = w_acc & ~w_cmd_err;
    assign sram_we    = (sram_cmd_read == CMD_WRITE);
    assign sram_wem   = sram_cmd_read ? '0 : sram_cmd_wmask;
    assign sram_wdata = sram_cmd_wdata;
    assign sram_addr  = sram_cmd_addr[c_OFF +: SRAM_AW];

`ifdef SRAM_CTRL_ADDR_CHK_EN
    logic w_misalign;
    logic w_oob;

    generate
        if (c_OFF > 0) begin : g_align_chk
            assign w_misalign = |sram_cmd_addr[c_OFF-1:0];
        end else begin : g_align_none
            assign w_misalign = 1'b0;
        end
    endgenerate

    // One extra bit so a MEM_BYTES equal to 2**AW never reads as zero.
    assign w_oob     = {1'b0, sram_cmd_addr} >= (AW+1)'(MEM_BYTES);
    assign w_cmd_err = w_misalign | w_oob;
`else
    logic w_unused_addr;

    // Address bits outside the word index are intentionally ignored.
    assign w_cmd_err     = 1'b0;
    assign w_unused_addr = ^{sram_cmd_addr, 32'(MEM_BYTES)};
`endif

    // ------------------------------------------------------------------
    // Credit counter: transactions accepted but not yet popped.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            case ({w_acc, w_pop})
                2'b10:   r_cnt <= r_cnt + c_CW'(1);
                2'b01:   r_cnt <= r_cnt - c_CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read-tracking pipeline, aligned so the last stage coincides with the
    // cycle sram_rdata is valid. Error and write commands carry rd=0 so
    // their response data is forced to zero.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
            r_rd  <= '0;
        end else begin
            r_vld[0] <= w_acc;
            r_rd[0]  <= w_acc & sram_cmd_read & ~w_cmd_err;
            for (int i = 1; i < c_LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_rd[i]  <= r_rd[i-1];
            end
        end
    end

    assign w_push     = r_vld[c_LAT-1];
    assign w_rdata_in = r_rd[c_LAT-1] ? sram_rdata : '0;

`ifdef SRAM_CTRL_ADDR_CHK_EN
    logic [c_LAT-1:0] r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= '0;
        end else begin
            r_err[0] <= w_acc & w_cmd_err;
            for (int i = 1; i < c_LAT; i++) begin
                r_err[i] <= r_err[i-1];
            end
        end
    end

    assign w_push_data    = {r_err[c_LAT-1], w_rdata_in};
    assign sram_rsp_err   = w_head[DW];
    assign sram_rsp_rdata = w_head[DW-1:0];
`else
    assign w_push_data    = w_rdata_in;
    assign sram_rsp_err   = 1'b0;
    assign sram_rsp_rdata = w_head;
`endif

    // ------------------------------------------------------------------
    // Response FIFO. Credits guarantee it never overflows, so full is
    // informational only.
    // ------------------------------------------------------------------
    logic w_unused_full;
    assign w_unused_full = w_fifo_full;

    sram_rsp_fifo #(
        .WIDTH (c_EW),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_pop_data  (w_head),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

endmodule
`default_nettype wire

// File: tb/tb_sram_ctrl_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sram_ctrl_pipe
//  Purpose  : Directed self-checking bench. Two controllers (RD_LAT=1 and
//             RD_LAT=2) share one command/response-ready stimulus, each with
//             its own behavioural SRAM model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sram_ctrl_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        cmd_vld;
    logic        cmd_read;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wmask;
    logic        rsp_rdy;

    logic        rdy_a, rsp_vld_a, rsp_err_a, cs_a, we_a;
    logic [31:0] rsp_rdata_a, swdata_a, srdata_a;
    logic [13:0] saddr_a;
    logic [3:0]  wem_a;
    logic        rdy_b, rsp_vld_b, rsp_err_b, cs_b, we_b;
    logic [31:0] rsp_rdata_b, swdata_b, srdata_b;
    logic [13:0] saddr_b;
    logic [3:0]  wem_b;

    sram_ctrl_pipe #(.RD_LAT(1), .RSP_DEPTH(4)) u_dut_a (
        .clk(clk), .rst(rst),
        .sram_cmd_vld(cmd_vld), .sram_cmd_rdy(rdy_a), .sram_cmd_addr(cmd_addr),
        .sram_cmd_read(cmd_read), .sram_cmd_wdata(cmd_wdata), .sram_cmd_wmask(cmd_wmask),
        .sram_rsp_vld(rsp_vld_a), .sram_rsp_rdy(rsp_rdy), .sram_rsp_err(rsp_err_a),
        .sram_rsp_rdata(rsp_rdata_a), .sram_cs(cs_a), .sram_we(we_a), .sram_addr(saddr_a),
        .sram_wem(wem_a), .sram_wdata(swdata_a), .sram_rdata(srdata_a)
    );

    sram_ctrl_pipe #(.RD_LAT(2), .RSP_DEPTH(4)) u_dut_b (
        .clk(clk), .rst(rst),
        .sram_cmd_vld(cmd_vld), .sram_cmd_rdy(rdy_b), .sram_cmd_addr(cmd_addr),
        .sram_cmd_read(cmd_read), .sram_cmd_wdata(cmd_wdata), .sram_cmd_wmask(cmd_wmask),
        .sram_rsp_vld(rsp_vld_b), .sram_rsp_rdy(rsp_rdy), .sram_rsp_err(rsp_err_b),
        .sram_rsp_rdata(rsp_rdata_b), .sram_cs(cs_b), .sram_we(we_b), .sram_addr(saddr_b),
        .sram_wem(wem_b), .sram_wdata(swdata_b), .sram_rdata(srdata_b)
    );

    // Behavioural SRAMs: byte-masked writes, reads valid RD_LAT cycles after cs.
    logic [31:0] mem_a [0:16383];
    logic [31:0] mem_b [0:16383];
    logic [31:0] q_a1, q_b1, q_b2;

    always @(posedge clk) begin
        if (cs_a) begin
            if (we_a) begin
                for (int i = 0; i < 4; i++)
                    if (wem_a[i]) mem_a[saddr_a][8*i +: 8] <= swdata_a[8*i +: 8];
            end else begin
                q_a1 <= mem_a[saddr_a];
            end
        end
    end
    assign srdata_a = q_a1;

    always @(posedge clk) begin
        q_b2 <= q_b1;
        if (cs_b) begin
            if (we_b) begin
                for (int i = 0; i < 4; i++)
                    if (wem_b[i]) mem_b[saddr_b][8*i +: 8] <= swdata_b[8*i +: 8];
            end else begin
                q_b1 <= mem_b[saddr_b];
            end
        end
    end
    assign srdata_b = q_b2;

    // Response monitor and accept counters.
    typedef struct {
        int          cyc;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    rsp_t q_a[$];
    rsp_t q_b[$];
    int   cyc   = 0;
    int   acc_a = 0;
    int   acc_b = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rsp_vld_a && rsp_rdy) q_a.push_back(rsp_t'{cyc, rsp_rdata_a, rsp_err_a});
        if (rsp_vld_b && rsp_rdy) q_b.push_back(rsp_t'{cyc, rsp_rdata_b, rsp_err_b});
        if (cmd_vld && rdy_a) acc_a = acc_a + 1;
        if (cmd_vld && rdy_b) acc_b = acc_b + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; cmd_vld = 1'b1; cmd_read = 1'b1; cmd_addr = 32'h0; rsp_rdy = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({cs_a, cs_b, rdy_a, rdy_b, rsp_vld_a, rsp_vld_b} !== 6'b0) begin
                errors++;
                $display("FAIL reset_outputs cyc%0d got cs/rdy/vld=%b want 000000", i,
                         {cs_a, cs_b, rdy_a, rdy_b, rsp_vld_a, rsp_vld_b});
            end
            tick();
        end
        rst = 1'b0; cmd_vld = 1'b0;
        @(negedge clk);
        checks++;
        if ({rdy_a, rdy_b, rsp_vld_a, rsp_vld_b} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_release got rdy/vld=%b want 1100", {rdy_a, rdy_b, rsp_vld_a, rsp_vld_b});
        end
    endtask

    task automatic test_write_read;
        int          t0;
        logic [31:0] exp_d [4];
        exp_d = '{32'h0, 32'hDEADBEEF, 32'h0, 32'hDE22BE44};
        q_a.delete(); q_b.delete();
        tick();
        rsp_rdy = 1'b1;
        cmd_vld = 1'b1; cmd_read = 1'b0; cmd_addr = 32'h10; cmd_wdata = 32'hDEADBEEF; cmd_wmask = 4'hF;
        t0 = cyc;
        @(negedge clk);
        checks++;
        if ({rdy_a, cs_a, we_a, saddr_a, wem_a} !== {3'b111, 14'd4, 4'hF}) begin
            errors++;
            $display("FAIL wr_request got rdy/cs/we=%b addr=%0d wem=%h want 111 addr=4 wem=f",
                     {rdy_a, cs_a, we_a}, saddr_a, wem_a);
        end
        checks++;
        if (swdata_a !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL wr_wdata got %h want deadbeef", swdata_a);
        end
        tick();
        cmd_read = 1'b1;
        @(negedge clk);
        checks++;
        if ({cs_a, we_a, wem_a, saddr_b, rsp_vld_a} !== {2'b10, 4'h0, 14'd4, 1'b0}) begin
            errors++;
            $display("FAIL rd_request got cs/we=%b wem=%h addr_b=%0d rsp_vld=%b want 10 0 4 0",
                     {cs_a, we_a}, wem_a, saddr_b, rsp_vld_a);
        end
        tick();
        cmd_vld = 1'b0;
        @(negedge clk);
        checks++;
        if ({rsp_vld_a, rsp_err_a, rsp_rdata_a} !== {2'b10, 32'h0}) begin
            errors++;
            $display("FAIL wr_rsp got vld/err=%b rdata=%h want 10 00000000", {rsp_vld_a, rsp_err_a}, rsp_rdata_a);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({rsp_vld_a, rsp_rdata_a} !== {1'b1, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL rd_rsp got vld=%b rdata=%h want 1 deadbeef", rsp_vld_a, rsp_rdata_a);
        end
        tick();
        cmd_vld = 1'b1; cmd_read = 1'b0; cmd_wdata = 32'h11223344; cmd_wmask = 4'b0101;
        tick();
        cmd_read = 1'b1;
        tick();
        cmd_vld = 1'b0;
        repeat (6) tick();
        checks++;
        if (q_a.size() != 4 || q_b.size() != 4) begin
            errors++;
            $display("FAIL wr_rd_count got a=%0d b=%0d want 4 4", q_a.size(), q_b.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (q_a[k].data !== exp_d[k] || q_b[k].data !== exp_d[k]) begin
                    errors++;
                    $display("FAIL wr_rd_data[%0d] got a=%h b=%h want %h", k, q_a[k].data, q_b[k].data, exp_d[k]);
                end
            end
            checks++;
            if (q_a[0].cyc != t0 + 2 || q_b[0].cyc != t0 + 3) begin
                errors++;
                $display("FAIL wr_rd_latency got a=%0d b=%0d want %0d %0d", q_a[0].cyc - t0, q_b[0].cyc - t0, 2, 3);
            end
        end
    endtask

    task automatic test_stream;
        int t0;
        q_a.delete(); q_b.delete();
        rsp_rdy = 1'b1;
        cmd_vld = 1'b1; cmd_read = 1'b1;
        t0 = cyc;
        for (int k = 0; k < 16; k++) begin
            cmd_addr = 32'((16 + k) * 4);
            @(negedge clk);
            checks++;
            if ({rdy_a, rdy_b} !== 2'b11) begin
                errors++;
                $display("FAIL stream_rdy[%0d] got %b want 11", k, {rdy_a, rdy_b});
            end
            tick();
        end
        cmd_vld = 1'b0;
        repeat (6) tick();
        checks++;
        if (q_a.size() != 16 || q_b.size() != 16) begin
            errors++;
            $display("FAIL stream_count got a=%0d b=%0d want 16 16", q_a.size(), q_b.size());
        end else begin
            for (int k = 0; k < 16; k++) begin
                checks++;
                if (q_b[k].data !== 32'hA5000010 + 32'(k) || q_b[k].cyc != t0 + 3 + k ||
                    q_a[k].data !== 32'hA5000010 + 32'(k) || q_a[k].cyc != t0 + 2 + k) begin
                    errors++;
                    $display("FAIL stream_rsp[%0d] got b=%h@%0d a=%h@%0d want %h @ %0d/%0d", k,
                             q_b[k].data, q_b[k].cyc - t0, q_a[k].data, q_a[k].cyc - t0,
                             32'hA5000010 + 32'(k), 3 + k, 2 + k);
                end
            end
        end
    endtask

    task automatic test_back_pressure;
        int n;
        q_a.delete(); q_b.delete();
        acc_a = 0; acc_b = 0; n = 0;
        rsp_rdy = 1'b0; cmd_vld = 1'b1; cmd_read = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cmd_addr = 32'((16 + n) * 4);
            @(negedge clk);
            if (rdy_a) n++;
            tick();
        end
        checks++;
        if (acc_a != 4 || acc_b != 4) begin
            errors++;
            $display("FAIL bp_accepts got a=%0d b=%0d want 4 4", acc_a, acc_b);
        end
        cmd_addr = 32'((16 + n) * 4);
        @(negedge clk);
        checks++;
        if ({rdy_a, rdy_b} !== 2'b00) begin
            errors++;
            $display("FAIL bp_stall got rdy=%b want 00", {rdy_a, rdy_b});
        end
        tick();
        rsp_rdy = 1'b1;
        @(negedge clk);
        checks++;
        if ({rdy_a, rdy_b, rsp_vld_a, rsp_vld_b} !== 4'b1111) begin
            errors++;
            $display("FAIL bp_pulse got rdy/vld=%b want 1111", {rdy_a, rdy_b, rsp_vld_a, rsp_vld_b});
        end
        tick();
        rsp_rdy = 1'b0;
        checks++;
        if (acc_a != 5 || acc_b != 5) begin
            errors++;
            $display("FAIL bp_one_more got a=%0d b=%0d want 5 5", acc_a, acc_b);
        end
        @(negedge clk);
        checks++;
        if ({rdy_a, rdy_b} !== 2'b00) begin
            errors++;
            $display("FAIL bp_restall got rdy=%b want 00", {rdy_a, rdy_b});
        end
        tick();
        cmd_vld = 1'b0; rsp_rdy = 1'b1;
        repeat (8) tick();
        checks++;
        if (q_a.size() != 5 || q_b.size() != 5) begin
            errors++;
            $display("FAIL bp_drain_count got a=%0d b=%0d want 5 5", q_a.size(), q_b.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (q_a[k].data !== 32'hA5000010 + 32'(k) || q_b[k].data !== 32'hA5000010 + 32'(k)) begin
                    errors++;
                    $display("FAIL bp_order[%0d] got a=%h b=%h want %h", k, q_a[k].data, q_b[k].data,
                             32'hA5000010 + 32'(k));
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        rsp_rdy = 1'b0; cmd_vld = 1'b1; cmd_read = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cmd_addr = 32'((16 + k) * 4);
            tick();
        end
        cmd_vld = 1'b0; rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({rsp_vld_a, rsp_vld_b} !== 2'b11) begin
            errors++;
            $display("FAIL mid_buffered got vld=%b want 11", {rsp_vld_a, rsp_vld_b});
        end
        tick();
        rst = 1'b0; rsp_rdy = 1'b1;
        q_a.delete(); q_b.delete();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({rsp_vld_a, rsp_vld_b} !== 2'b00) begin
                errors++;
                $display("FAIL mid_flushed[%0d] got vld=%b want 00", i, {rsp_vld_a, rsp_vld_b});
            end
            tick();
        end
        cmd_vld = 1'b1; cmd_addr = 32'h50;
        tick();
        cmd_vld = 1'b0;
        repeat (5) tick();
        checks++;
        if (q_a.size() != 1 || q_b.size() != 1) begin
            errors++;
            $display("FAIL mid_after_count got a=%0d b=%0d want 1 1", q_a.size(), q_b.size());
        end else begin
            checks++;
            if (q_a[0].data !== 32'hA5000014 || q_b[0].data !== 32'hA5000014) begin
                errors++;
                $display("FAIL mid_after_data got a=%h b=%h want a5000014", q_a[0].data, q_b[0].data);
            end
        end
    endtask

`ifdef SRAM_CTRL_ADDR_CHK_EN
    task automatic test_addr_chk;
        logic [31:0] addrs  [3];
        logic [2:0]  exp_cs;
        logic [31:0] exp_d  [3];
        logic [2:0]  exp_err;
        addrs   = '{32'h10000, 32'h0, 32'h3};
        exp_cs  = 3'b010;
        exp_d   = '{32'h0, 32'hA5000000, 32'h0};
        exp_err = 3'b101;
        q_a.delete(); q_b.delete();
        rsp_rdy = 1'b1; cmd_vld = 1'b1; cmd_read = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cmd_addr = addrs[k];
            @(negedge clk);
            checks++;
            if ({cs_a, cs_b, rdy_a} !== {exp_cs[2-k], exp_cs[2-k], 1'b1}) begin
                errors++;
                $display("FAIL chk_cs[%0d] got cs/rdy=%b want %b1", k, {cs_a, cs_b, rdy_a}, {2{exp_cs[2-k]}});
            end
            tick();
        end
        cmd_vld = 1'b0;
        repeat (6) tick();
        checks++;
        if (q_a.size() != 3 || q_b.size() != 3) begin
            errors++;
            $display("FAIL chk_count got a=%0d b=%0d want 3 3", q_a.size(), q_b.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if ({q_a[k].err, q_a[k].data} !== {exp_err[2-k], exp_d[k]} ||
                    {q_b[k].err, q_b[k].data} !== {exp_err[2-k], exp_d[k]}) begin
                    errors++;
                    $display("FAIL chk_rsp[%0d] got a=%b/%h b=%b/%h want %b/%h", k, q_a[k].err, q_a[k].data,
                             q_b[k].err, q_b[k].data, exp_err[2-k], exp_d[k]);
                end
            end
        end
    endtask
`endif

    initial begin
        rst = 1'b1; cmd_vld = 1'b0; cmd_read = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_wmask = '0; rsp_rdy = 1'b0;
        for (int i = 0; i < 64; i++) begin
            mem_a[i] = 32'hA5000000 + 32'(i);
            mem_b[i] = 32'hA5000000 + 32'(i);
        end
        test_reset();
        test_write_read();
        test_stream();
        test_back_pressure();
        test_reset_mid();
`ifdef SRAM_CTRL_ADDR_CHK_EN
        test_addr_chk();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
